// File: rtl/eth_phy_sim_pkg.sv
// Shared definitions for the Ethernet PHY simulation helpers.
//   BLOCK_W / WINDOW_W : 66-bit line block and the 132-bit two-block window
//   OFFSET_W           : width of a bit offset inside one block (0..65)
//   rx_state_t         : slip-model control states
//   SYNC_DATA/CTRL     : 64b/66b sync header values
//   next_offset()      : offset increment with 65 -> 0 wrap
package eth_phy_sim_pkg;

    localparam int BLOCK_W    = 66;
    localparam int WINDOW_W   = 2 * BLOCK_W;
    localparam int OFFSET_W   = 7;
    localparam int MAX_OFFSET = BLOCK_W - 1;
    // Index width able to address every bit of the 132-bit window.
    localparam int IDX_W      = 8;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SLIP_WAIT  = 2'd1,
        RESET_HOLD = 2'd2
    } rx_state_t;

    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        return (off == OFFSET_W'(MAX_OFFSET)) ? '0 : off + 1'b1;
    endfunction

endpackage

// File: rtl/serdes_rx_bitslip_model_bit_window_shifter.sv
// bit_window_shifter: combinational barrel slice of a two-block window.
//   window : {newer block, older block}, bit 0 = first bit on the wire
//   offset : start bit of the slice, 0..65
//   slice  : window[offset +: 66]
// Kept independent of the RX model so a TX-side slip model can reuse it.
module bit_window_shifter
    import eth_phy_sim_pkg::*;
(
    input  logic [WINDOW_W-1:0] window,
    input  logic [OFFSET_W-1:0] offset,
    output logic [BLOCK_W-1:0]  slice
);

    // Per-bit mux with an explicitly sized index; offset never exceeds 65,
    // so the highest bit addressed is 130.
    always_comb begin
        slice = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            slice[i] = window[IDX_W'(i) + {1'b0, offset}];
        end
    end

endmodule

// File: rtl/serdes_rx_bitslip_model.sv
// serdes_rx_bitslip_model: SerDes receive-side loopback model with a
// controllable bit misalignment. Takes the 66-bit block stream from the PHY
// transmitter and presents it to the PHY receiver shifted by cur_offset bits,
// answering the receiver's bitslip and SerDes-reset requests.
//   rx_clk, rx_rst          : clock; synchronous active-low reset
//   in_data, in_hdr         : block from PHY TX (hdr[0] is first on the wire)
//   serdes_rx_data/hdr      : misaligned block to PHY RX (registered)
//   serdes_rx_bitslip       : slip request; each rising edge asks for +1 bit
//   serdes_rx_reset_req     : forces outputs to zero for RESET_HOLD_CYCLES,
//                             then restores INIT_OFFSET
//   inject_hdr_err          : zero the next output header
//   cur_offset              : offset used for the block now on the outputs
//   slip_count              : accepted slips, wraps at 256
//   slip_dropped            : one-cycle pulse for each ignored bitslip edge
// DATA_WIDTH and HDR_WIDTH must stay 64 and 2.
module serdes_rx_bitslip_model
    import eth_phy_sim_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int HDR_WIDTH         = 2,
    parameter int INIT_OFFSET       = 0,
    parameter int SLIP_LATENCY      = 2,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    input  logic                  serdes_rx_bitslip,
    input  logic                  serdes_rx_reset_req,
    input  logic                  inject_hdr_err,
    output logic [OFFSET_W-1:0]   cur_offset,
    output logic [7:0]            slip_count,
    output logic                  slip_dropped
);

    localparam int CNT_MAX = (SLIP_LATENCY > RESET_HOLD_CYCLES) ? SLIP_LATENCY
                                                               : RESET_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [OFFSET_W-1:0] INIT_OFF  = OFFSET_W'(INIT_OFFSET);
    localparam logic [CNT_W-1:0]    SLIP_LOAD = CNT_W'(SLIP_LATENCY - 1);
    localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(RESET_HOLD_CYCLES - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [OFFSET_W-1:0]  offset;
    logic [BLOCK_W-1:0]   prev_blk;
    logic [BLOCK_W-1:0]   out_blk;
    logic                 bitslip_q;

    logic [BLOCK_W-1:0]   blk;
    logic [WINDOW_W-1:0]  window;
    logic [BLOCK_W-1:0]   slice;
    logic [OFFSET_W-1:0]  sel_offset;
    logic                 rise;
    logic                 blank;

    assign blk    = {in_data, in_hdr};
    assign window = {blk, prev_blk};
    assign rise   = serdes_rx_bitslip & ~bitslip_q;

    // Outputs are forced to zero on the request cycle and while the hold
    // counter is still running. On the final hold cycle (cnt == 0) the block
    // already goes out aligned to INIT_OFFSET, so exactly RESET_HOLD_CYCLES
    // blanked blocks are seen and the first block after the hold is valid.
    assign blank      = serdes_rx_reset_req || (state == RESET_HOLD && cnt != '0);
    assign sel_offset = (state == RESET_HOLD) ? INIT_OFF : offset;

    bit_window_shifter u_shifter (
        .window (window),
        .offset (sel_offset),
        .slice  (slice)
    );

    always_ff @(posedge rx_clk) begin
        if (!rx_rst) begin
            state        <= RUN;
            cnt          <= '0;
            offset       <= INIT_OFF;
            cur_offset   <= INIT_OFF;
            prev_blk     <= '0;
            out_blk      <= '0;
            bitslip_q    <= 1'b0;
            slip_count   <= '0;
            slip_dropped <= 1'b0;
        end else begin
            // Block capture runs in every state, including the reset hold.
            prev_blk     <= blk;
            bitslip_q    <= serdes_rx_bitslip;
            cur_offset   <= sel_offset;
            slip_dropped <= 1'b0;

            if (blank) begin
                out_blk <= '0;
            end else begin
                out_blk <= slice;
                if (inject_hdr_err && state != RESET_HOLD) begin
                    out_blk[1:0] <= 2'b00;
                end
            end

            if (serdes_rx_reset_req) begin
                // Reset request wins over any bitslip edge seen this cycle.
                state        <= RESET_HOLD;
                cnt          <= HOLD_LOAD;
                slip_dropped <= rise;
            end else begin
                case (state)
                    RUN: begin
                        if (rise) begin
                            state <= SLIP_WAIT;
                            cnt   <= SLIP_LOAD;
                        end
                    end
                    SLIP_WAIT: begin
                        slip_dropped <= rise;
                        if (cnt == '0) begin
                            offset     <= next_offset(offset);
                            slip_count <= slip_count + 8'd1;
                            state      <= RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    RESET_HOLD: begin
                        slip_dropped <= rise;
                        if (cnt == '0) begin
                            offset <= INIT_OFF;
                            state  <= RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign serdes_rx_hdr  = out_blk[HDR_WIDTH-1:0];
    assign serdes_rx_data = out_blk[BLOCK_W-1:HDR_WIDTH];

endmodule

// File: tb/tb_serdes_rx_bitslip_model.sv
// Directed bench for serdes_rx_bitslip_model (INIT_OFFSET=0, SLIP_LATENCY=4,
// RESET_HOLD_CYCLES=16). Slip tests use a constant stream with only bit 0
// set (hdr=01, data=0), so offset k moves that bit to position 66-k.
module tb_serdes_rx_bitslip_model;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic [63:0] serdes_rx_data;
    logic [1:0]  serdes_rx_hdr;
    logic        serdes_rx_bitslip;
    logic        serdes_rx_reset_req;
    logic        inject_hdr_err;
    logic [6:0]  cur_offset;
    logic [7:0]  slip_count;
    logic        slip_dropped;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] IDLE_DATA = 64'h0707070707070707;
    localparam logic [63:0] SEQ_BASE  = 64'h0123456789AB0000;

    always #5 rx_clk = ~rx_clk;

    serdes_rx_bitslip_model #(
        .DATA_WIDTH        (64),
        .HDR_WIDTH         (2),
        .INIT_OFFSET       (0),
        .SLIP_LATENCY      (4),
        .RESET_HOLD_CYCLES (16)
    ) dut (
        .rx_clk              (rx_clk),
        .rx_rst              (rx_rst),
        .in_data             (in_data),
        .in_hdr              (in_hdr),
        .serdes_rx_data      (serdes_rx_data),
        .serdes_rx_hdr       (serdes_rx_hdr),
        .serdes_rx_bitslip   (serdes_rx_bitslip),
        .serdes_rx_reset_req (serdes_rx_reset_req),
        .inject_hdr_err      (inject_hdr_err),
        .cur_offset          (cur_offset),
        .slip_count          (slip_count),
        .slip_dropped        (slip_dropped)
    );

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    // One slip request: edge, then wait out SLIP_LATENCY=4 cycles.
    task automatic do_slip();
        serdes_rx_bitslip = 1'b1;
        tick();
        serdes_rx_bitslip = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rx_rst = 1'b0;
        in_data = IDLE_DATA;
        in_hdr  = 2'b10;
        tick();
        tick();
        checks++; if (serdes_rx_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", serdes_rx_data); end
        checks++; if (serdes_rx_hdr !== 2'b00) begin errors++; $display("FAIL reset_hdr: got %b expected 00", serdes_rx_hdr); end
        checks++; if (cur_offset !== 7'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", cur_offset); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL reset_slip_count: got %0d expected 0", slip_count); end
        checks++; if (slip_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", slip_dropped); end
        rx_rst = 1'b1;
        tick();
        checks++; if (serdes_rx_hdr !== 2'b00) begin errors++; $display("FAIL latency_one_cycle_hdr: got %b expected 00", serdes_rx_hdr); end
        tick();
        checks++; if (serdes_rx_hdr !== 2'b10) begin errors++; $display("FAIL idle_hdr: got %b expected 10", serdes_rx_hdr); end
        checks++; if (serdes_rx_data !== IDLE_DATA) begin errors++; $display("FAIL idle_data: got %h expected %h", serdes_rx_data, IDLE_DATA); end
        checks++; if (cur_offset !== 7'd0) begin errors++; $display("FAIL idle_offset: got %0d expected 0", cur_offset); end
    endtask

    task automatic test_passthrough();
        logic [63:0] exp_d;
        logic [1:0]  exp_h;
        for (int i = 0; i < 6; i++) begin
            in_data = SEQ_BASE + 64'(i);
            in_hdr  = (i % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            if (i >= 1) begin
                exp_d = SEQ_BASE + 64'(i - 1);
                exp_h = ((i - 1) % 2 == 1) ? 2'b10 : 2'b01;
                checks++; if (serdes_rx_data !== exp_d || serdes_rx_hdr !== exp_h) begin
                    errors++; $display("FAIL passthrough_%0d: got %h/%b expected %h/%b", i, serdes_rx_data, serdes_rx_hdr, exp_d, exp_h);
                end
            end
        end
    endtask

    task automatic test_inject_hdr_err();
        in_data = IDLE_DATA;
        in_hdr  = 2'b10;
        tick();
        tick();
        inject_hdr_err = 1'b1;
        tick();
        inject_hdr_err = 1'b0;
        checks++; if (serdes_rx_hdr !== 2'b00) begin errors++; $display("FAIL inject_hdr: got %b expected 00", serdes_rx_hdr); end
        checks++; if (serdes_rx_data !== IDLE_DATA) begin errors++; $display("FAIL inject_data: got %h expected %h", serdes_rx_data, IDLE_DATA); end
        tick();
        checks++; if (serdes_rx_hdr !== 2'b10) begin errors++; $display("FAIL inject_recover: got %b expected 10", serdes_rx_hdr); end
    endtask

    task automatic test_slip_drop();
        in_data = 64'd0;
        in_hdr  = 2'b01;
        repeat (3) tick();
        serdes_rx_bitslip = 1'b1;
        tick();                              // accepted edge
        serdes_rx_bitslip = 1'b0;
        tick();
        serdes_rx_bitslip = 1'b1;
        tick();                              // second edge inside SLIP_WAIT
        serdes_rx_bitslip = 1'b0;
        checks++; if (slip_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", slip_dropped); end
        tick();
        checks++; if (slip_dropped !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %b expected 0", slip_dropped); end
        checks++; if (slip_count !== 8'd0) begin errors++; $display("FAIL slip_too_early: got %0d expected 0", slip_count); end
        tick();
        checks++; if (slip_count !== 8'd1) begin errors++; $display("FAIL slip_latency: got %0d expected 1", slip_count); end
        tick();
        checks++; if (cur_offset !== 7'd1) begin errors++; $display("FAIL slip_offset1: got %0d expected 1", cur_offset); end
        checks++; if (serdes_rx_data !== 64'h8000000000000000 || serdes_rx_hdr !== 2'b00) begin
            errors++; $display("FAIL slip_data1: got %h/%b expected 8000000000000000/00", serdes_rx_data, serdes_rx_hdr);
        end
        repeat (4) tick();
        checks++; if (slip_count !== 8'd1 || cur_offset !== 7'd1) begin
            errors++; $display("FAIL drop_no_extra_slip: got count %0d offset %0d expected 1/1", slip_count, cur_offset);
        end
    endtask

    task automatic test_held_bitslip();
        int drops = 0;
        serdes_rx_bitslip = 1'b1;
        repeat (10) begin
            tick();
            if (slip_dropped === 1'b1) drops++;
        end
        serdes_rx_bitslip = 1'b0;
        tick();
        checks++; if (drops !== 0) begin errors++; $display("FAIL held_drops: got %0d expected 0", drops); end
        checks++; if (slip_count !== 8'd2 || cur_offset !== 7'd2) begin
            errors++; $display("FAIL held_single_slip: got count %0d offset %0d expected 2/2", slip_count, cur_offset);
        end
        checks++; if (serdes_rx_data !== 64'h4000000000000000 || serdes_rx_hdr !== 2'b00) begin
            errors++; $display("FAIL held_data: got %h/%b expected 4000000000000000/00", serdes_rx_data, serdes_rx_hdr);
        end
    endtask

    task automatic test_wrap();
        repeat (63) do_slip();
        tick();
        checks++; if (cur_offset !== 7'd65 || slip_count !== 8'd65) begin
            errors++; $display("FAIL wrap_at_65: got offset %0d count %0d expected 65/65", cur_offset, slip_count);
        end
        checks++; if (serdes_rx_hdr !== 2'b10 || serdes_rx_data !== 64'd0) begin
            errors++; $display("FAIL wrap_data65: got %h/%b expected 0/10", serdes_rx_data, serdes_rx_hdr);
        end
        do_slip();
        tick();
        checks++; if (cur_offset !== 7'd0 || slip_count !== 8'd66) begin
            errors++; $display("FAIL wrap_to_0: got offset %0d count %0d expected 0/66", cur_offset, slip_count);
        end
        checks++; if (serdes_rx_hdr !== 2'b01 || serdes_rx_data !== 64'd0) begin
            errors++; $display("FAIL wrap_data0: got %h/%b expected 0/01", serdes_rx_data, serdes_rx_hdr);
        end
    endtask

    task automatic test_reset_req();
        int bad = 0;
        repeat (30) do_slip();
        tick();
        checks++; if (cur_offset !== 7'd30 || slip_count !== 8'd96) begin
            errors++; $display("FAIL pre_req_state: got offset %0d count %0d expected 30/96", cur_offset, slip_count);
        end
        checks++; if (serdes_rx_data !== 64'h0000000400000000) begin
            errors++; $display("FAIL offset30_data: got %h expected 0000000400000000", serdes_rx_data);
        end
        serdes_rx_reset_req = 1'b1;
        serdes_rx_bitslip   = 1'b1;
        tick();
        serdes_rx_reset_req = 1'b0;
        serdes_rx_bitslip   = 1'b0;
        checks++; if (serdes_rx_hdr !== 2'b00) begin errors++; $display("FAIL req_blank0: got %b expected 00", serdes_rx_hdr); end
        checks++; if (slip_dropped !== 1'b1) begin errors++; $display("FAIL req_edge_dropped: got %b expected 1", slip_dropped); end
        repeat (15) begin
            tick();
            if (serdes_rx_hdr !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL req_hold_blank: got %0d unblanked cycles expected 0", bad); end
        tick();
        checks++; if (serdes_rx_hdr !== 2'b01) begin errors++; $display("FAIL req_first_valid: got %b expected 01", serdes_rx_hdr); end
        checks++; if (cur_offset !== 7'd0) begin errors++; $display("FAIL req_offset_init: got %0d expected 0", cur_offset); end
        checks++; if (slip_count !== 8'd96) begin errors++; $display("FAIL req_count_kept: got %0d expected 96", slip_count); end
        repeat (6) tick();
        checks++; if (slip_count !== 8'd96 || cur_offset !== 7'd0) begin
            errors++; $display("FAIL req_no_late_slip: got count %0d offset %0d expected 96/0", slip_count, cur_offset);
        end
    endtask

    task automatic test_reset_mid_slip();
        repeat (3) do_slip();
        serdes_rx_bitslip = 1'b1;
        tick();
        serdes_rx_bitslip = 1'b0;
        tick();
        rx_rst = 1'b0;
        tick();
        checks++; if (cur_offset !== 7'd0 || slip_count !== 8'd0) begin
            errors++; $display("FAIL midslip_reset: got offset %0d count %0d expected 0/0", cur_offset, slip_count);
        end
        checks++; if (serdes_rx_hdr !== 2'b00 || serdes_rx_data !== 64'd0) begin
            errors++; $display("FAIL midslip_outputs: got %h/%b expected 0/00", serdes_rx_data, serdes_rx_hdr);
        end
        rx_rst = 1'b1;
        repeat (6) tick();
        checks++; if (slip_count !== 8'd0 || cur_offset !== 7'd0 || serdes_rx_hdr !== 2'b01) begin
            errors++; $display("FAIL midslip_run: got count %0d offset %0d hdr %b expected 0/0/01", slip_count, cur_offset, serdes_rx_hdr);
        end
    endtask

    initial begin
        rx_rst              = 1'b0;
        in_data             = '0;
        in_hdr              = '0;
        serdes_rx_bitslip   = 1'b0;
        serdes_rx_reset_req = 1'b0;
        inject_hdr_err      = 1'b0;
        test_reset();
        test_passthrough();
        test_inject_hdr_err();
        test_slip_drop();
        test_held_bitslip();
        test_wrap();
        test_reset_req();
        test_reset_mid_slip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serdes_rx_bitslip_model.md
Name: serdes_rx_bitslip_model

Overview:
Behavioural-synthesizable SerDes receive-side model that closes the PHY loopback path. It takes the 66-bit block stream from the PHY transmitter (serdes_tx_data/serdes_tx_hdr) and presents it to the PHY receiver with a controllable bit misalignment. It is the responder end of the PHY's serdes_rx_bitslip / serdes_rx_reset_req handshake. Benches use it to exercise block-lock acquisition, BER monitoring and the watchdog under realistic slips.

Parameters:
DATA_WIDTH, 64, payload bits per block (fixed 64; other values unsupported)
HDR_WIDTH, 2, sync header bits (fixed 2)
INIT_OFFSET, 0, bit offset loaded at reset and after a reset request, 0..65
SLIP_LATENCY, 2, cycles from bitslip rising edge to the offset change, >=1
RESET_HOLD_CYCLES, 16, cycles the output is forced invalid after reset_req, >=1

Ports:
rx_clk  in  1  clock, shared by both stream sides
rx_rst  in  1  synchronous, active-low reset (0 = reset)
in_data  in  64  block payload from PHY TX
in_hdr  in  2  sync header from PHY TX
serdes_rx_data  out  64  misaligned payload to PHY RX
serdes_rx_hdr  out  2  misaligned header to PHY RX
serdes_rx_bitslip  in  1  slip request from PHY RX
serdes_rx_reset_req  in  1  SerDes reset request from PHY RX
inject_hdr_err  in  1  force the next output header to 2'b00
cur_offset  out  7  current bit offset, 0..65
slip_count  out  8  accepted slips, wraps 255->0
slip_dropped  out  1  one-cycle pulse when a bitslip edge is ignored

Behaviour:
- Block word B = {in_data, in_hdr}; bit 0 is hdr[0], the first bit on the wire.
- Registers prev_blk (66b). Window W = {B_t, prev_blk} (132b). The output block for cycle t+1 is W[offset +: 66], registered. serdes_rx_hdr = out[1:0], serdes_rx_data = out[65:2].
- Latency: offset 0 outputs B_{t-1} at t+1, so input-to-output is 2 cycles and the block is unchanged.
- Reset (rx_rst==0, sampled at posedge): prev_blk=0, outputs data=0 and hdr=2'b00, offset=INIT_OFFSET, slip_count=0, slip_dropped=0, state=RUN, edge-detect register=0.
- FSM states RUN, SLIP_WAIT, RESET_HOLD:
  - RUN: a rising edge on serdes_rx_bitslip (cur=1, prev=0) loads the wait counter with SLIP_LATENCY-1 and moves to SLIP_WAIT.
  - SLIP_WAIT: the counter decrements. At 0: offset = (offset==65) ? 0 : offset+1, slip_count++, back to RUN. A rising edge in SLIP_WAIT is ignored and pulses slip_dropped.
  - RESET_HOLD: outputs data=0 and hdr=2'b00. The counter runs RESET_HOLD_CYCLES, then offset=INIT_OFFSET and state goes to RUN. Data flow and prev_blk capture continue throughout, so the first block after hold is valid. Bitslip edges here are ignored and pulse slip_dropped.
- serdes_rx_reset_req==1 in any state enters RESET_HOLD and restarts its counter. reset_req has priority over a simultaneous bitslip edge; that edge is dropped.
- Bitslip held high for many cycles counts as one edge. The PHY's BITSLIP_HIGH/LOW pacing is the requester's responsibility.
- inject_hdr_err: the output header at t+1 becomes 2'b00 and data is unaffected. Ignored in RESET_HOLD.
- cur_offset reflects the offset used for the current output.
- Offset wrap-around 65->0 is seamless: no duplicated or lost block.

Decomposition:
- Shared package eth_phy_sim_pkg holds BLOCK_W=66, OFFSET_W=7, the state enum {RUN, SLIP_WAIT, RESET_HOLD}, and SYNC_DATA=2'b01 / SYNC_CTRL=2'b10.
- One natural sub-module, bit_window_shifter: combinational 132→66 barrel slice indexed by offset. It is reused by any future TX-side slip model.

Test Plan:
- Reset, INIT_OFFSET=0, drive in_hdr=2'b10 and in_data=64'h0707070707070707 continuously → from 2 cycles after reset release, serdes_rx_hdr=2'b10, data matches exactly, cur_offset=0.
- INIT_OFFSET=5, looped into eth_phy_10g (SCRAMBLER_DISABLE=1, idle stream) → the PHY issues bitslips, the model accepts 61 slips, cur_offset reaches 0 (wraps 65->0), rx_block_lock=1 follows, slip_count=61.
- Two bitslip edges 1 cycle apart with SLIP_LATENCY=4 → the second is ignored, slip_dropped pulses once, offset advances by exactly 1.
- reset_req asserted with offset=30 on the same cycle as a bitslip edge → hdr=2'b00 for 16 cycles, then offset=INIT_OFFSET, the bitslip edge is dropped, slip_count is unchanged.
- inject_hdr_err pulsed 16 times within 125 cycles while locked (PHY COUNT_125US=125) → the PHY asserts rx_high_ber=1. Pulsing it once → rx_error_count increments by 1 and lock holds.
- Assert rx_rst=0 mid-SLIP_WAIT → the next cycle shows state RUN, offset=INIT_OFFSET, outputs zero, slip_count=0.
